// File: rtl/gcm_din_packer_pkg.sv
// rtl/gcm_din_packer_pkg.sv - block constants and keep-mask helpers for the din packer
package gcm_din_packer_pkg;

    localparam int BLK_W     = 128;
    localparam int BLK_BYTES = 16;

    // Expand a byte keep (bit i covers bits [8i+7:8i]) into a bit mask.
    function automatic logic [BLK_W-1:0] keep_to_bytemask(input logic [BLK_BYTES-1:0] keep);
        logic [BLK_W-1:0] m;
        m = '0;
        for (int i = 0; i < BLK_BYTES; i++) begin
            m[8*i +: 8] = {8{keep[i]}};
        end
        return m;
    endfunction

    // Non-last words need all kw bits set; last words need a nonzero MSB-contiguous run.
    function automatic logic keep_ok(input logic [BLK_BYTES-1:0] keep, input int kw, input logic last);
        logic ok;
        ok = 1'b0;
        if (!last) begin
            ok = (keep == (16'hFFFF >> (BLK_BYTES - kw)));
        end else begin
            for (int n = 1; n <= BLK_BYTES; n++) begin
                if (n <= kw && keep == ((16'hFFFF >> (BLK_BYTES - n)) << (kw - n))) begin
                    ok = 1'b1;
                end
            end
        end
        return ok;
    endfunction

    function automatic logic [4:0] keep_bytes(input logic [BLK_BYTES-1:0] keep);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < BLK_BYTES; i++) begin
            cnt = cnt + 5'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gcm_din_packer_if.sv
// rtl/gcm_din_packer_if.sv - narrow word input stream and 128-bit din block stream
interface gcm_din_packer_if #(
    parameter int IN_W = 32
);
    logic [IN_W-1:0]   s_data_i;
    logic [IN_W/8-1:0] s_keep_i;
    logic              s_last_i;
    logic              s_valid_i;
    logic              s_ready_o;
    logic [127:0]      din_o;
    logic              din_valid_o;
    logic              din_ready_i;
    logic              din_last_o;
    logic [4:0]        din_bytes_o;

    // Packer side: sinks the word stream, sources the block stream.
    modport master (
        input  s_data_i, s_keep_i, s_last_i, s_valid_i, din_ready_i,
        output s_ready_o, din_o, din_valid_o, din_last_o, din_bytes_o
    );

    modport slave (
        output s_data_i, s_keep_i, s_last_i, s_valid_i, din_ready_i,
        input  s_ready_o, din_o, din_valid_o, din_last_o, din_bytes_o
    );
endinterface

// File: rtl/gcm_din_packer.sv
// rtl/gcm_din_packer.sv - packs IN_W words into zero-padded 128-bit blocks for aes_gcm
module gcm_din_packer
    import gcm_din_packer_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    output logic               err_o,
    gcm_din_packer_if.master   bus
);

    localparam int WPB   = BLK_W / IN_W;
    localparam int KW    = IN_W / 8;
    localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;

    logic [BLK_W-1:0] r_asm_data;
    logic [IDX_W-1:0] r_idx;
    logic             r_asm_full;
    logic             r_asm_last;
    logic [4:0]       r_asm_bytes;
    logic [BLK_W-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic [4:0]       r_out_bytes;
    logic             r_s_ready;
    logic             r_err;

    logic             w_accept;
    logic             w_fire;
    logic             w_keep_ok;
    logic [KW-1:0]    w_keep_eff;
    logic [IN_W-1:0]  w_word;
    logic [BLK_W-1:0] w_blk;
    logic             w_end;
    logic             w_complete;
    logic [4:0]       w_bytes;
    logic             w_out_free;

    always_comb begin
        w_accept   = bus.s_valid_i && r_s_ready;
        w_fire     = r_out_valid && bus.din_ready_i;
        w_keep_ok  = keep_ok(16'(bus.s_keep_i), KW, bus.s_last_i);
        w_keep_eff = w_keep_ok ? bus.s_keep_i : {KW{1'b1}};
        w_word     = bus.s_data_i & IN_W'(keep_to_bytemask(16'(w_keep_eff)));
        // Slot 0 starts from zero so unused slots of a short block are padding.
        w_blk      = (r_idx == '0) ? '0 : r_asm_data;
        w_blk[BLK_W-1 - int'(r_idx)*IN_W -: IN_W] = w_word;
        w_end      = (r_idx == IDX_W'(WPB-1)) || bus.s_last_i;
        w_complete = w_accept && w_end;
        w_bytes    = bus.s_last_i ? 5'(int'(r_idx)*KW) + keep_bytes(16'(w_keep_eff))
                                  : 5'(BLK_BYTES);
        w_out_free = !r_out_valid || w_fire;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            r_asm_data  <= '0;
            r_idx       <= '0;
            r_asm_full  <= 1'b0;
            r_asm_last  <= 1'b0;
            r_asm_bytes <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_bytes <= '0;
            r_s_ready   <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            if (w_accept && !w_keep_ok) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                r_idx <= w_end ? '0 : r_idx + IDX_W'(1);
                if (!w_end) begin
                    r_asm_data <= w_blk;
                end
            end
            // A parked block blocks input, so it only needs to watch for the output firing.
            if (r_asm_full) begin
                if (w_fire) begin
                    r_out_data  <= r_asm_data;
                    r_out_last  <= r_asm_last;
                    r_out_bytes <= r_asm_bytes;
                    r_asm_full  <= 1'b0;
                    r_s_ready   <= 1'b1;
                end
            end else if (w_complete) begin
                if (w_out_free) begin
                    r_out_data  <= w_blk;
                    r_out_valid <= 1'b1;
                    r_out_last  <= bus.s_last_i;
                    r_out_bytes <= w_bytes;
                end else begin
                    r_asm_data  <= w_blk;
                    r_asm_full  <= 1'b1;
                    r_asm_last  <= bus.s_last_i;
                    r_asm_bytes <= w_bytes;
                    r_s_ready   <= 1'b0;
                end
            end else if (w_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.s_ready_o   = r_s_ready;
    assign bus.din_o       = r_out_data;
    assign bus.din_valid_o = r_out_valid;
    assign bus.din_last_o  = r_out_last;
    assign bus.din_bytes_o = r_out_bytes;
    assign err_o           = r_err;

endmodule
